// File: rtl/tmr_scrub_writer_pkg.sv
`default_nettype none
// ==========================================================================
// tmr_scrub_writer_pkg : shared FSM states and correction-counter constants
// Rev 1.0
// ==========================================================================
package tmr_scrub_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_SRD   = 3'd2,
    ST_SVOTE = 3'd3,
    ST_SWB   = 3'd4
  } state_e;

  localparam int                  C_CORR_W   = 16;
  localparam logic [C_CORR_W-1:0] C_CORR_SAT = 16'hFFFF;

  function automatic logic [C_CORR_W-1:0] sat_inc(input logic [C_CORR_W-1:0] v);
    return (v == C_CORR_SAT) ? v : v + C_CORR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_scrub_writer_edac.sv
`default_nettype none
// ==========================================================================
// tmr_scrub_writer_edac : bitwise 2-of-3 majority voter with mismatch flag
// Rev 1.0
// ==========================================================================
module tmr_scrub_writer_edac #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] data_a_i,
  input  logic [BITS-1:0] data_b_i,
  input  logic [BITS-1:0] data_c_i,
  output logic [BITS-1:0] data_o,
  output logic            err_det_c_o
);

  assign data_o      = (data_a_i & data_b_i) | (data_a_i & data_c_i) | (data_b_i & data_c_i);
  assign err_det_c_o = |((data_a_i ^ data_b_i) | (data_a_i ^ data_c_i));

endmodule
`default_nettype wire

// File: rtl/tmr_scrub_writer.sv
`default_nettype none
// ==========================================================================
// tmr_scrub_writer : host write fan-out and background scrub of TMR RAM
// Rev 1.0
// ==========================================================================
module tmr_scrub_writer
  import tmr_scrub_writer_pkg::*;
#(
  parameter int BITS           = 8,
  parameter int ADDR_BITS      = 10,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_req_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [BITS-1:0]      wr_data_i,
  output logic                 wr_ack_o,
  input  logic                 scrub_en_i,
  output logic [ADDR_BITS-1:0] ram_addr_o,
  output logic [2:0]           ram_we_o,
  output logic [BITS-1:0]      ram_wdata_o,
  input  logic [BITS-1:0]      ram_rda_i,
  input  logic [BITS-1:0]      ram_rdb_i,
  input  logic [BITS-1:0]      ram_rdc_i,
  output logic                 scrub_err_o,
  output logic [C_CORR_W-1:0]  corr_cnt_o,
  output logic                 scrub_busy_o
);

  localparam int              C_IW       = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [C_IW-1:0] C_IVL_TERM = C_IW'(SCRUB_INTERVAL - 1);

  state_e                 state_q;
  logic [ADDR_BITS-1:0]   saddr_q;
  logic [C_IW-1:0]        ivl_q;
  logic                   pending_q;
  logic [ADDR_BITS-1:0]   ram_addr_q;
  logic [2:0]             ram_we_q;
  logic [BITS-1:0]        ram_wdata_q;
  logic                   wr_ack_q;
  logic                   scrub_err_q;
  logic [C_CORR_W-1:0]    corr_cnt_q;
  logic                   busy_q;

  logic [BITS-1:0]        vote_word;
  logic                   vote_err;
  logic                   scrub_start;
  logic                   ivl_tick;

  tmr_scrub_writer_edac #(.BITS(BITS)) u_edac (
    .data_a_i    (ram_rda_i),
    .data_b_i    (ram_rdb_i),
    .data_c_i    (ram_rdc_i),
    .data_o      (vote_word),
    .err_det_c_o (vote_err)
  );

  // Host has priority: a scrub only starts from IDLE with no write waiting.
  assign scrub_start = (state_q == ST_IDLE) && !wr_req_i && scrub_en_i && pending_q;
  assign ivl_tick    = (ivl_q == C_IVL_TERM);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !scrub_en_i) begin
      ivl_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      ivl_q <= ivl_tick ? '0 : ivl_q + C_IW'(1);
      if (scrub_start) begin
        pending_q <= 1'b0;
      end else if (ivl_tick) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      saddr_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 3'b000;
      ram_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      scrub_err_q <= 1'b0;
      corr_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ram_we_q    <= 3'b000;
      wr_ack_q    <= 1'b0;
      scrub_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_req_i) begin
            state_q     <= ST_WRITE;
            ram_addr_q  <= wr_addr_i;
            ram_wdata_q <= wr_data_i;
            ram_we_q    <= 3'b111;
            wr_ack_q    <= 1'b1;
          end else if (scrub_start) begin
            state_q    <= ST_SRD;
            ram_addr_q <= saddr_q;
            busy_q     <= 1'b1;
          end
        end
        ST_WRITE: state_q <= ST_IDLE;
        ST_SRD:   state_q <= ST_SVOTE;
        ST_SVOTE: begin
          // ram_addr_q still holds the scrub address for the write-back
          if (vote_err) begin
            state_q     <= ST_SWB;
            ram_wdata_q <= vote_word;
            ram_we_q    <= 3'b111;
            scrub_err_q <= 1'b1;
            corr_cnt_q  <= sat_inc(corr_cnt_q);
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            saddr_q <= saddr_q + ADDR_BITS'(1);
          end
        end
        ST_SWB: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          saddr_q <= saddr_q + ADDR_BITS'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ack_o     = wr_ack_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_we_o     = ram_we_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign scrub_err_o  = scrub_err_q;
  assign corr_cnt_o   = corr_cnt_q;
  assign scrub_busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_scrub_writer.sv
`default_nettype none
// ==========================================================================
// tb_tmr_scrub_writer : TMR RAM model, directed scenarios and random traffic
// Rev 1.0
// ==========================================================================
module tb_tmr_scrub_writer;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n, wr_req, wr_ack, scrub_en, scrub_err, scrub_busy;
  logic [AW-1:0] wr_addr, ram_addr;
  logic [7:0]    wr_data, ram_wdata, rda, rdb, rdc;
  logic [2:0]    ram_we;
  logic [15:0]   corr_cnt;

  logic          preload, inj_valid;
  logic [1:0]    inj_copy;
  logic [AW-1:0] inj_addr;
  logic [7:0]    inj_mask;
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [7:0]    mem_c [DEPTH];
  logic [7:0]    init_m[3][DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tmr_scrub_writer #(.BITS(8), .ADDR_BITS(AW), .SCRUB_INTERVAL(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_req_i(wr_req), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_ack_o(wr_ack), .scrub_en_i(scrub_en),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rda_i(rda), .ram_rdb_i(rdb), .ram_rdc_i(rdc),
    .scrub_err_o(scrub_err), .corr_cnt_o(corr_cnt), .scrub_busy_o(scrub_busy)
  );

  // Three RAM copies with synchronous read; write enable bits are {A,B,C}
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_a[k] <= init_m[0][k];
        mem_b[k] <= init_m[1][k];
        mem_c[k] <= init_m[2][k];
      end
    end else begin
      if (ram_we[2]) mem_a[ram_addr] <= ram_wdata;
      if (ram_we[1]) mem_b[ram_addr] <= ram_wdata;
      if (ram_we[0]) mem_c[ram_addr] <= ram_wdata;
      if (inj_valid) begin
        case (inj_copy)
          2'd0:    mem_a[inj_addr] <= mem_a[inj_addr] ^ inj_mask;
          2'd1:    mem_b[inj_addr] <= mem_b[inj_addr] ^ inj_mask;
          default: mem_c[inj_addr] <= mem_c[inj_addr] ^ inj_mask;
        endcase
      end
    end
    rda <= mem_a[ram_addr];
    rdb <= mem_b[ram_addr];
    rdc <= mem_c[ram_addr];
  end

  // Reference model: per-cycle expected outputs planned as a queue of records
  typedef struct {
    logic [2:0]    we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          ack, err, busy;
    logic [15:0]   corr;
    bit            ca, cd;
  } rec_t;

  rec_t       q[$];
  rec_t       exp;
  logic [7:0] mem_m[3][DEPTH];
  int         m_cnt, m_saddr, m_corr;
  bit         m_pend;

  function automatic rec_t mk(logic [2:0] we, logic [AW-1:0] a, logic [7:0] d, logic ack,
                              logic err, logic busy, int c, bit ca, bit cd);
    rec_t r;
    r.we = we; r.addr = a; r.wdata = d; r.ack = ack; r.err = err; r.busy = busy;
    r.corr = 16'(c); r.ca = ca; r.cd = cd;
    return r;
  endfunction

  function automatic rec_t idle_rec();
    return mk(3'b000, '0, 8'h00, 1'b0, 1'b0, 1'b0, m_corr, 1'b0, 1'b0);
  endfunction

  function automatic bit model_idle();
    return (q.size() == 0) && !exp.busy && (exp.we == 3'b000) && !exp.ack;
  endfunction

  task automatic model_step();
    logic [AW-1:0] a;
    logic [7:0]    v;
    bit            start, mism, tick_t;
    int            ones;
    if (preload) begin
      mem_m = init_m;
    end else begin
      if (exp.we == 3'b111)
        for (int k = 0; k < 3; k++) mem_m[k][exp.addr] = exp.wdata;
      if (inj_valid) mem_m[inj_copy][inj_addr] = mem_m[inj_copy][inj_addr] ^ inj_mask;
    end
    if (!rst_n) begin
      q.delete();
      m_cnt = 0; m_pend = 0; m_saddr = 0; m_corr = 0;
      exp = mk(3'b000, '0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      return;
    end
    start = 0;
    if (q.size() != 0) begin
      exp = q.pop_front();
    end else if (wr_req) begin
      exp = mk(3'b111, wr_addr, wr_data, 1'b1, 1'b0, 1'b0, m_corr, 1'b1, 1'b1);
      q.push_back(idle_rec());
    end else if (scrub_en && m_pend) begin
      start = 1;
      a = AW'(m_saddr);
      for (int b = 0; b < 8; b++) begin
        ones = int'(mem_m[0][a][b]) + int'(mem_m[1][a][b]) + int'(mem_m[2][a][b]);
        v[b] = (ones >= 2);
      end
      mism = !((mem_m[0][a] == mem_m[1][a]) && (mem_m[1][a] == mem_m[2][a]));
      exp = mk(3'b000, a, 8'h00, 1'b0, 1'b0, 1'b1, m_corr, 1'b1, 1'b0);
      q.push_back(mk(3'b000, a, 8'h00, 1'b0, 1'b0, 1'b1, m_corr, 1'b0, 1'b0));
      if (mism) begin
        if (m_corr < 65535) m_corr++;
        q.push_back(mk(3'b111, a, v, 1'b0, 1'b1, 1'b1, m_corr, 1'b1, 1'b1));
      end
      q.push_back(idle_rec());
      m_saddr = (m_saddr + 1) % DEPTH;
    end else begin
      exp = idle_rec();
    end
    if (!scrub_en) begin
      m_cnt = 0; m_pend = 0;
    end else begin
      tick_t = (m_cnt == 3);
      m_cnt  = tick_t ? 0 : m_cnt + 1;
      if (start) m_pend = 0;
      else if (tick_t) m_pend = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, want);
    end
  endtask

  task automatic check_cycle();
    chk("ram_we", 32'(ram_we), 32'(exp.we));
    chk("wr_ack", 32'(wr_ack), 32'(exp.ack));
    chk("scrub_err", 32'(scrub_err), 32'(exp.err));
    chk("scrub_busy", 32'(scrub_busy), 32'(exp.busy));
    chk("corr_cnt", 32'(corr_cnt), 32'(exp.corr));
    if (exp.ca) chk("ram_addr", 32'(ram_addr), 32'(exp.addr));
    if (exp.cd) chk("ram_wdata", 32'(ram_wdata), 32'(exp.wdata));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget expired", nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen1, seen2, done, found;
    int n_err, lat;
    logic [7:0] swb_data;

    exp = mk(3'b000, '0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rst_n = 0; wr_req = 0; wr_addr = '0; wr_data = '0; scrub_en = 0;
    preload = 1; inj_valid = 0; inj_copy = '0; inj_addr = '0; inj_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      for (int c = 0; c < 3; c++) init_m[c][k] = 8'h3C;
    init_m[1][2] = 8'h3D;
    tick();
    preload = 0;
    tick();
    tick();
    chk("reset_we", 32'(ram_we), 32'h0);
    chk("reset_corr", 32'(corr_cnt), 32'h0);
    chk("reset_busy", 32'(scrub_busy), 32'h0);

    // Host write: visible on the RAM port the cycle after acceptance
    rst_n = 1; wr_req = 1; wr_addr = 3'd5; wr_data = 8'hA5;
    tick();
    chk("t1_we", 32'(ram_we), 32'h7);
    chk("t1_addr", 32'(ram_addr), 32'h5);
    chk("t1_wdata", 32'(ram_wdata), 32'hA5);
    chk("t1_ack", 32'(wr_ack), 32'h1);
    chk("t1_corr", 32'(corr_cnt), 32'h0);
    wr_req = 0;
    tick();

    // Scrub addr 0/1 clean, addr 2 corrupted in B; host write raised in SRD of addr 2
    scrub_en = 1; seen1 = 0; seen2 = 0; done = 0; n_err = 0; lat = 0; swb_data = 8'h00;
    for (int i = 0; i < 120 && !done; i++) begin
      tick();
      if (scrub_err) begin
        n_err++;
        swb_data = ram_wdata;
      end
      if (!seen1 && scrub_busy && ram_addr == 3'd1) begin
        seen1 = 1;
        chk("t2_no_err_addr0", 32'(n_err), 32'h0);
      end
      if (wr_req) begin
        lat++;
        if (wr_ack) begin
          chk("t4_ack_latency_le4", 32'(lat <= 4), 32'h1);
          chk("t4_swb_before_write", 32'(n_err), 32'h1);
          wr_req = 0;
          done = 1;
        end
      end else if (!seen2 && scrub_busy && ram_addr == 3'd2 && ram_we == 3'b000) begin
        seen2 = 1;
        wr_req = 1; wr_addr = 3'd2; wr_data = 8'h77;
      end
    end
    if (!done) bound_fail("t4_wait_ack");
    tick();
    chk("t3_swb_data", 32'(swb_data), 32'h3C);
    chk("t3_corr", 32'(corr_cnt), 32'h1);
    chk("t4_ram_a", 32'(mem_a[2]), 32'h77);
    chk("t4_ram_b", 32'(mem_b[2]), 32'h77);
    chk("t4_ram_c", 32'(mem_c[2]), 32'h77);

    // Random contents, counter pushed near saturation, then random traffic
    scrub_en = 0; wr_req = 0; rst_n = 0;
    for (int k = 0; k < DEPTH; k++) begin
      init_m[0][k] = 8'($urandom);
      init_m[1][k] = init_m[0][k];
      init_m[2][k] = init_m[0][k];
      if ($urandom_range(0, 1) == 1)
        init_m[$urandom_range(0, 2)][k] ^= 8'(1 << $urandom_range(0, 7));
    end
    preload = 1;
    tick();
    preload = 0;
    tick();
    rst_n = 1;
    tick();
    force dut.corr_cnt_q = 16'hFFFE;
    m_corr = 16'hFFFE;
    tick();
    release dut.corr_cnt_q;
    scrub_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if (wr_req && wr_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          wr_addr = AW'($urandom);
          wr_data = 8'($urandom);
        end else begin
          wr_req = 0;
        end
      end else if (!wr_req && $urandom_range(0, 7) == 0) begin
        wr_req = 1;
        wr_addr = AW'($urandom);
        wr_data = 8'($urandom);
      end
      if (scrub_en ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0))
        scrub_en = !scrub_en;
      inj_valid = model_idle() && ($urandom_range(0, 3) == 0);
      inj_copy  = 2'($urandom_range(0, 2));
      inj_addr  = AW'($urandom);
      inj_mask  = 8'(1 << $urandom_range(0, 7));
      tick();
    end
    inj_valid = 0;
    chk("t5_corr_saturated", 32'(corr_cnt), 32'hFFFF);

    // Reset asserted in the middle of a write-back
    wr_req = 0; scrub_en = 1; found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      inj_valid = 0;
      if (i == 3 || (i > 3 && model_idle() && (i % 40) == 0)) begin
        inj_valid = 1; inj_copy = 2'd0; inj_addr = AW'(m_saddr); inj_mask = 8'h01;
      end
      tick();
      if (scrub_err) found = 1;
    end
    inj_valid = 0;
    if (!found) bound_fail("t6_wait_swb");
    rst_n = 0;
    tick();
    chk("t6_we", 32'(ram_we), 32'h0);
    chk("t6_err", 32'(scrub_err), 32'h0);
    chk("t6_corr", 32'(corr_cnt), 32'h0);
    chk("t6_busy", 32'(scrub_busy), 32'h0);
    rst_n = 1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
